mux_stream: RTL and testbench
=============================

Name: mux_stream

Overview:
- Parametrised successor of the fixed 5-way combinational selector.
- N-channel streaming multiplexer with valid/ready handshakes on every input and on the output, plus one registered output stage.
- Two selection modes:
  - Explicit select: a select port chooses the channel.
  - Round-robin: channels are arbitrated fairly.
- Sits between multiple producer blocks and a single consumer in schematic-generated datapaths.

Parameters:
- WIDTH, 8, data width in bits per channel (true width, not width-1).
- N, 5, number of input channels, 2..16.
- SELW, 3, width of select/channel-index fields; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = explicit select via s, 1 = round-robin.
- s  input  SELW  channel select used when mode=0.
- in_valid  input  N  per-channel data valid.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; at most one bit high.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_chan  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=N-1, so the first search starts at channel 0.
  - Reset wins over any simultaneous handshake; a beat held in the register is discarded.
- load_en = !out_valid || out_ready. This is combinational and gives full throughput: one beat per cycle when the consumer is always ready.
- Grant (combinational, from the current inputs and state):
  - mode=0: g = s if s < N, else g = N-1 (out-of-range select maps to the last channel, as in the previous generation). Grant is asserted only if in_valid[g]=1.
  - mode=1: g = first i with in_valid[i]=1, searching last+1, last+2, ... modulo N. No grant if in_valid is all zero.
- in_ready[i] = load_en && grant_valid && (g==i). Nothing is accepted from a non-granted channel even if it is valid.
- Transfer in = in_valid[g] && in_ready[g]. On a transfer-in edge: out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- If out_valid && out_ready and there is no transfer-in: out_valid <= 0. out_data and out_chan hold their last values.
- If out_valid && !out_ready: out_valid, out_data and out_chan are all held stable (no change until accepted).
- Latency: one cycle from input acceptance to out_valid.
- Round-robin pointer:
  - last <= g on every transfer-in, in either mode.
  - Switching mode to 1 therefore continues after the most recently served channel.
- Mode or s changes take effect in the same cycle's grant. They never disturb a beat already in the output register.
- Inputs are expected to keep in_valid/in_data stable until accepted. The block does not check this.
- No combinational path from out_ready to out_data. A combinational path from out_ready to in_ready is permitted.

Test Plan:
- Reset, then hold mode=0, s=2, in_valid=5'b00100, in_data ch2=8'hA5, out_ready=1 -> in_ready=5'b00100 in the same cycle; next cycle out_valid=1, out_data=A5, out_chan=2.
- mode=0, s=7 (out of range), N=5, in_valid=5'b10000, ch4=8'h3C -> in_ready[4]=1; next cycle out_data=3C, out_chan=4. With s=7 and in_valid=5'b00001 -> no in_ready bit set and out_valid stays 0.
- Backpressure: load a beat with out_ready=0 for 3 cycles while ch1 remains valid -> out_valid=1, data and chan stable, in_ready=0 throughout. Raise out_ready -> the held beat is accepted and the ch1 beat loads in that same cycle (no bubble).
- Round-robin: mode=1, in_valid=5'b11111 constant, out_ready=1, from reset -> out_chan sequence 0,1,2,3,4,0,1 on consecutive cycles. Then with in_valid=5'b01010 -> sequence alternates 3,1,3,1.
- Mode switch: mode=0, s=3, one beat from ch3; then mode=1 with all channels valid -> next grants are 4,0,1.
- Reset mid-operation: out_valid=1 with out_ready=0, assert rst for 1 cycle while ch0 is valid -> out_valid=0, out_data=0, out_chan=0 after the edge, no beat accepted in that cycle. The next round-robin grant is ch0.

Source files
------------

// File: rtl/mux_stream.sv
// mux_stream: N-channel valid/ready stream multiplexer with one registered
// output stage. Channel choice is either an explicit select (mode=0) or a
// fair round-robin search starting after the most recently served channel.
module mux_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 5,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      s,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    localparam int NPAD = 2 ** SELW;

    // Output register and round-robin pointer
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_data_q;
    logic [SELW-1:0]      out_chan_q;
    logic [SELW-1:0]      last_q;

    // Channel views padded to the full select range so any SELW-bit index is legal
    logic [NPAD-1:0]      valid_pad;
    logic [WIDTH-1:0]     chan_data [NPAD];

    // Grant results
    logic [SELW-1:0]      grant;
    logic                 grant_valid;
    logic                 load_en;
    logic                 transfer_in;
    logic [SELW:0]        rr_sum;
    logic [SELW-1:0]      rr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NPAD; gi++) begin : g_pad
            if (gi < N) begin : g_real
                assign valid_pad[gi] = in_valid[gi];
                assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
            end else begin : g_unused
                assign valid_pad[gi] = 1'b0;
                assign chan_data[gi] = '0;
            end
        end
    endgenerate

    // The register can take a new beat when empty or being drained this cycle
    assign load_en     = !out_valid_q || out_ready;
    assign transfer_in = load_en && grant_valid;

    // Grant selection: explicit select with out-of-range clamp, or round-robin search
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        rr_sum      = '0;
        rr_idx      = '0;
        if (!mode) begin
            if ({1'b0, s} < (SELW+1)'(N)) begin
                grant = s;
            end else begin
                grant = SELW'(N - 1);
            end
            grant_valid = valid_pad[grant];
        end else begin
            // Walk from the farthest candidate back to the nearest so the
            // nearest valid channel after last_q is the one that sticks.
            for (int k = N; k >= 1; k--) begin
                rr_sum = {1'b0, last_q} + (SELW+1)'(k);
                if (rr_sum >= (SELW+1)'(N)) begin
                    rr_sum = rr_sum - (SELW+1)'(N);
                end
                rr_idx = rr_sum[SELW-1:0];
                if (valid_pad[rr_idx]) begin
                    grant       = rr_idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = transfer_in && (grant == SELW'(gi));
        end
    endgenerate

    // Output stage: load on transfer-in, drop valid when drained, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last_q      <= SELW'(N - 1);
        end else if (transfer_in) begin
            out_valid_q <= 1'b1;
            out_data_q  <= chan_data[grant];
            out_chan_q  <= grant;
            last_q      <= grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_stream.sv
// Testbench for mux_stream: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the selector kept here.
module tb_mux_stream;

    localparam int W    = 8;
    localparam int N    = 5;
    localparam int SELW = 3;

    logic             clk;
    logic             rst;
    logic             mode;
    logic [SELW-1:0]  s;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_chan;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_last;
    bit          m_ov;
    logic [W-1:0] m_od;
    int          m_oc;

    mux_stream #(.WIDTH(W), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .s         (s),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Which channel the rules pick from the current inputs
    function automatic void model_grant(output int g, output bit gv);
        g  = 0;
        gv = 1'b0;
        if (!mode) begin
            g  = (int'(s) < N) ? int'(s) : N - 1;
            gv = in_valid[g];
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (in_valid[c]) begin
                    g  = c;
                    gv = 1'b1;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        bit gv;
        model_grant(g, gv);
        if ((!m_ov || out_ready) && gv) return N'(1) << g;
        return '0;
    endfunction

    // Advance the model across one clock edge, then move past the edge
    task automatic cycle();
        int g;
        bit gv;
        bit ld;
        model_grant(g, gv);
        ld = !m_ov || out_ready;
        if (rst) begin
            m_ov = 1'b0; m_od = '0; m_oc = 0; m_last = N - 1;
        end else if (ld && gv) begin
            m_ov = 1'b1; m_od = in_data[g*W +: W]; m_oc = g; m_last = g;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan(input int ch, input logic [W-1:0] d);
        in_data[ch*W +: W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mode = 1'b0; s = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b d=%h c=%0d, want v=0 d=00 c=0", out_valid, out_data, out_chan);
        end
        checks++;
        if (in_ready !== 5'b00000) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 00000", in_ready);
        end
        $display("reset: v=%0b d=%h c=%0d", out_valid, out_data, out_chan);
    endtask

    task automatic test_explicit();
        mode = 1'b0; s = 3'd2; in_valid = 5'b00100; set_chan(2, 8'hA5); out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 5'b00100) begin
            errors++;
            $display("FAIL explicit_ready: got %b want 00100", in_ready);
        end
        cycle();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 3'd2) begin
            errors++;
            $display("FAIL explicit_out: got v=%0b d=%h c=%0d, want v=1 d=a5 c=2", out_valid, out_data, out_chan);
        end
        $display("explicit: s=2 -> d=%h c=%0d", out_data, out_chan);
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL explicit_drain: got v=%0b want 0", out_valid);
        end
    endtask

    task automatic test_out_of_range();
        mode = 1'b0; s = 3'd7; in_valid = 5'b10000; set_chan(4, 8'h3C); out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 5'b10000) begin
            errors++;
            $display("FAIL oor_ready: got %b want 10000", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_chan !== 3'd4) begin
            errors++;
            $display("FAIL oor_out: got v=%0b d=%h c=%0d, want v=1 d=3c c=4", out_valid, out_data, out_chan);
        end
        in_valid = 5'b00001; set_chan(0, 8'h99);
        #1;
        checks++;
        if (in_ready !== 5'b00000) begin
            errors++;
            $display("FAIL oor_noready: got %b want 00000", in_ready);
        end
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL oor_novalid: got v=%0b want 0", out_valid);
        end
        in_valid = '0;
        $display("out_of_range: s=7 maps to ch4");
    endtask

    task automatic test_backpressure();
        mode = 1'b0; s = 3'd1; in_valid = 5'b00010; set_chan(1, 8'h11); out_ready = 1'b0;
        cycle();
        set_chan(1, 8'h22);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 5'b00000) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b want 00000", i, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 || out_chan !== 3'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%0b d=%h c=%0d, want v=1 d=11 c=1", i, out_valid, out_data, out_chan);
            end
            cycle();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 5'b00010) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 00010", in_ready);
        end
        cycle();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22 || out_chan !== 3'd1) begin
            errors++;
            $display("FAIL bp_nobubble: got v=%0b d=%h c=%0d, want v=1 d=22 c=1", out_valid, out_data, out_chan);
        end
        $display("backpressure: released beat d=%h", out_data);
        cycle();
    endtask

    task automatic test_round_robin();
        int seq_a [7];
        int seq_b [4];
        seq_a = '{0, 1, 2, 3, 4, 0, 1};
        seq_b = '{3, 1, 3, 1};
        mode = 1'b0; in_valid = '0; out_ready = 1'b1;
        do_reset();
        mode = 1'b1; in_valid = 5'b11111;
        for (int i = 0; i < N; i++) set_chan(i, W'($urandom));
        for (int i = 0; i < 7; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b1 || int'(out_chan) !== seq_a[i] || out_data !== m_od) begin
                errors++;
                $display("FAIL rr_all[%0d]: got v=%0b c=%0d d=%h, want v=1 c=%0d d=%h", i, out_valid, out_chan, out_data, seq_a[i], m_od);
            end
            $display("rr all-valid step %0d: chan=%0d", i, out_chan);
        end
        in_valid = 5'b01010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (int'(out_chan) !== seq_b[i]) begin
                errors++;
                $display("FAIL rr_sparse[%0d]: got c=%0d want c=%0d", i, out_chan, seq_b[i]);
            end
            $display("rr sparse step %0d: chan=%0d", i, out_chan);
        end
        in_valid = '0;
        cycle();
    endtask

    task automatic test_mode_switch();
        int seq [3];
        seq = '{4, 0, 1};
        mode = 1'b0; in_valid = '0; out_ready = 1'b1;
        do_reset();
        s = 3'd3; in_valid = 5'b01000; set_chan(3, 8'h5A);
        cycle();
        checks++;
        if (out_chan !== 3'd3 || out_data !== 8'h5A) begin
            errors++;
            $display("FAIL ms_first: got c=%0d d=%h want c=3 d=5a", out_chan, out_data);
        end
        mode = 1'b1; in_valid = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (int'(out_chan) !== seq[i]) begin
                errors++;
                $display("FAIL ms_rr[%0d]: got c=%0d want c=%0d", i, out_chan, seq[i]);
            end
            $display("mode switch grant %0d: chan=%0d", i, out_chan);
        end
        in_valid = '0;
        cycle();
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; s = 3'd0; in_valid = 5'b00001; set_chan(0, 8'h77); out_ready = 1'b0;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            errors++;
            $display("FAIL rm_load: got v=%0b d=%h want v=1 d=77", out_valid, out_data);
        end
        rst = 1'b1; out_ready = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 3'd0) begin
            errors++;
            $display("FAIL rm_clear: got v=%0b d=%h c=%0d want v=0 d=00 c=0", out_valid, out_data, out_chan);
        end
        mode = 1'b1; in_valid = 5'b11111;
        #1;
        checks++;
        if (in_ready !== 5'b00001) begin
            errors++;
            $display("FAIL rm_next_grant: got %b want 00001", in_ready);
        end
        $display("reset mid-op: next in_ready=%b", in_ready);
        cycle();
        in_valid = '0;
        cycle();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mode      = 1'($urandom);
            s         = SELW'($urandom);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) set_chan(c, W'($urandom));
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++; bad++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, model_ready());
            end
            cycle();
            checks++;
            if (out_valid !== m_ov || (m_ov && (out_data !== m_od || int'(out_chan) !== m_oc))) begin
                errors++; bad++;
                $display("FAIL rand_out[%0d]: got v=%0b d=%h c=%0d want v=%0b d=%h c=%0d",
                         i, out_valid, out_data, out_chan, m_ov, m_od, m_oc);
            end
        end
        rst = 1'b0;
        $display("random: 400 cycles, %0d discrepancies", bad);
    endtask

    initial begin
        rst = 1'b0; mode = 1'b0; s = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        m_last = N - 1; m_ov = 1'b0; m_od = '0; m_oc = 0;
        #1;
        test_reset();
        test_explicit();
        test_out_of_range();
        test_backpressure();
        test_round_robin();
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
